// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller.
package pipe_ctrl_pkg;
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } state_e;

   localparam int DMEM_TIMEOUT_DEF = 16;
endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones once it gets there.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] cnt
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with data-memory wait timeout.
// Optional perf counters when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int DMEM_TIMEOUT = DMEM_TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_use_hazard,
   input  logic        branch_taken_ex,
   input  logic        dmem_req_ex,
   input  logic        dmem_ready,
   input  logic        imem_ready,
   output logic        pc_en,
   output logic        if_id_en,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        ex_hold,
   output logic        halt,
   output logic        dmem_err
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
`endif
);
   localparam int CW = $clog2(DMEM_TIMEOUT);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      ex_hold     = 1'b0;
      halt        = 1'b0;
      dmem_err    = 1'b0;
      unique case (state_q)
         RUN: begin
            if (dmem_req_ex && !dmem_ready) begin
               pc_en    = 1'b0;
               if_id_en = 1'b0;
               ex_hold  = 1'b1;
               state_d  = MEM_WAIT;
               cnt_d    = '0;
            end else if (branch_taken_ex) begin
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
            end else if (load_use_hazard) begin
               pc_en       = 1'b0;
               if_id_en    = 1'b0;
               id_ex_flush = 1'b1;
            end else if (!imem_ready) begin
               pc_en       = 1'b0;
               if_id_flush = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (!dmem_ready) begin
               pc_en    = 1'b0;
               if_id_en = 1'b0;
               ex_hold  = 1'b1;
               // Leave before the counter could wrap.
               if (cnt_q == CW'(DMEM_TIMEOUT - 1)) state_d = ERR;
               else                                 cnt_d   = cnt_q + CW'(1);
            end else begin
               state_d = RUN;
               if (load_use_hazard) begin
                  pc_en       = 1'b0;
                  if_id_en    = 1'b0;
                  id_ex_flush = 1'b1;
               end else if (!imem_ready) begin
                  pc_en       = 1'b0;
                  if_id_flush = 1'b1;
               end
            end
         end
         ERR: begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            ex_hold  = 1'b1;
            halt     = 1'b1;
            dmem_err = 1'b1;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   sat_counter #(.W(32)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (!pc_en),
      .cnt   (stall_cycles)
   );

   sat_counter #(.W(32)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (id_ex_flush),
      .cnt   (flush_count)
   );
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random stimulus
// against a cycle-level behavioural model.
module tb_pipe_ctrl;
   localparam int T = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic load_use_hazard = 1'b0, branch_taken_ex = 1'b0, dmem_req_ex = 1'b0;
   logic dmem_ready = 1'b0, imem_ready = 1'b1;
   logic pc_en, if_id_en, if_id_flush, id_ex_flush, ex_hold, halt, dmem_err;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cycles, flush_count;
`endif

   pipe_ctrl #(.DMEM_TIMEOUT(T)) dut (
      .clk(clk), .rst_n(rst_n),
      .load_use_hazard(load_use_hazard), .branch_taken_ex(branch_taken_ex),
      .dmem_req_ex(dmem_req_ex), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
      .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
      .id_ex_flush(id_ex_flush), .ex_hold(ex_hold), .halt(halt), .dmem_err(dmem_err)
`ifdef PIPE_CTRL_PERF_EN
      , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // Model: are we waiting on data memory, how many cycles already waited, errored?
   bit m_wait = 0;
   int m_waited = 0;
   bit m_err = 0;
   logic [6:0] exp_o;

   // {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_hold, halt, dmem_err}
   function automatic logic [6:0] obs();
      return {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_hold, halt, dmem_err};
   endfunction

   function automatic logic [6:0] model_out();
      if (m_err) return 7'b0000111;
      if ((m_wait || dmem_req_ex) && !dmem_ready) return 7'b0000100;
      if (!m_wait && branch_taken_ex) return 7'b1111000;
      if (load_use_hazard) return 7'b0001000;
      if (!imem_ready) return 7'b0110000;
      return 7'b1100000;
   endfunction

   function automatic void model_step();
      if (m_err) return;
      if (m_wait) begin
         if (dmem_ready) m_wait = 0;
         else begin
            m_waited++;
            if (m_waited == T) begin
               m_err = 1;
               m_wait = 0;
            end
         end
      end else if (dmem_req_ex && !dmem_ready) begin
         m_wait = 1;
         m_waited = 0;
      end
   endfunction

   function automatic void model_reset();
      m_wait = 0;
      m_waited = 0;
      m_err = 0;
   endfunction

   // Advance one cycle: commit the previous inputs at the edge, drive new ones.
   task automatic apply(input logic lu, br, dr, rdy, imr);
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
      load_use_hazard = lu;
      branch_taken_ex = br;
      dmem_req_ex     = dr;
      dmem_ready      = rdy;
      imem_ready      = imr;
      #1;
      exp_o = model_out();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      load_use_hazard = 0; branch_taken_ex = 0; dmem_req_ex = 0;
      dmem_ready = 0; imem_ready = 1;
      model_reset();
      #1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      n_vec++;
      if (obs() !== 7'b1100000) begin
         n_bad++;
         $display("FAIL reset_outputs: got %b want %b", obs(), 7'b1100000);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_load_use();
      logic [6:0] want [2] = '{7'b0001000, 7'b1100000};
      do_reset();
      apply(1, 0, 0, 0, 1);
      n_vec++;
      if (obs() !== want[0] || exp_o !== want[0]) begin
         n_bad++;
         $display("FAIL load_use_stall: got %b want %b", obs(), want[0]);
      end
      apply(0, 0, 0, 0, 1);
      n_vec++;
      if (obs() !== want[1]) begin
         n_bad++;
         $display("FAIL load_use_release: got %b want %b", obs(), want[1]);
      end
   endtask

   task automatic test_branch_priority();
      apply(1, 1, 0, 0, 1);
      n_vec++;
      if (obs() !== 7'b1111000) begin
         n_bad++;
         $display("FAIL branch_over_load_use: got %b want %b", obs(), 7'b1111000);
      end
      apply(0, 0, 0, 0, 1);
      n_vec++;
      if (obs() !== 7'b1100000) begin
         n_bad++;
         $display("FAIL branch_release: got %b want %b", obs(), 7'b1100000);
      end
   endtask

`ifdef PIPE_CTRL_PERF_EN
   task automatic test_perf();
      do_reset();
      apply(1, 0, 0, 0, 1);
      apply(0, 0, 0, 0, 1);
      apply(1, 1, 0, 0, 1);
      apply(0, 0, 0, 0, 1);
      n_vec++;
      if (stall_cycles !== 32'd1 || flush_count !== 32'd2) begin
         n_bad++;
         $display("FAIL perf_counts: got stall=%0d flush=%0d want stall=1 flush=2",
                  stall_cycles, flush_count);
      end
   endtask
`endif

   task automatic test_mem_wait();
      logic [6:0] want [4] = '{7'b0000100, 7'b0000100, 7'b1100000, 7'b1100000};
      logic       rdy  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic       dr   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         apply(0, 0, dr[i], rdy[i], 1);
         n_vec++;
         if (obs() !== want[i] || exp_o !== want[i]) begin
            n_bad++;
            $display("FAIL mem_wait_c%0d: got %b want %b", i + 1, obs(), want[i]);
         end
      end
   endtask

   task automatic test_timeout();
      do_reset();
      apply(0, 0, 1, 0, 1);
      for (int c = 2; c <= 5; c++) begin
         apply(0, 0, 1, 0, 1);
         n_vec++;
         if (obs() !== 7'b0000100) begin
            n_bad++;
            $display("FAIL timeout_wait_c%0d: got %b want %b", c, obs(), 7'b0000100);
         end
      end
      for (int c = 6; c <= 8; c++) begin
         apply(c == 7, c == 8, 0, c == 8, 1);
         n_vec++;
         if (obs() !== 7'b0000111) begin
            n_bad++;
            $display("FAIL timeout_err_c%0d: got %b want %b", c, obs(), 7'b0000111);
         end
      end
      #2;
      rst_n = 1'b0;
      load_use_hazard = 0; branch_taken_ex = 0; dmem_req_ex = 0; imem_ready = 1;
      model_reset();
      #1;
      n_vec++;
      if (halt !== 1'b0 || dmem_err !== 1'b0 || pc_en !== 1'b1) begin
         n_bad++;
         $display("FAIL async_reset_clear: got halt=%b err=%b pc_en=%b want 0 0 1",
                  halt, dmem_err, pc_en);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_imem_stall();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         apply(0, 0, 0, 0, 0);
         n_vec++;
         if (obs() !== 7'b0110000) begin
            n_bad++;
            $display("FAIL imem_stall_c%0d: got %b want %b", i, obs(), 7'b0110000);
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if (i % 60 == 59) do_reset();
         apply(($urandom % 5) == 0, ($urandom % 6) == 0, ($urandom % 3) == 0,
               ($urandom % 2) == 0, ($urandom % 5) != 0);
         n_vec++;
         if (obs() !== exp_o) begin
            n_bad++;
            $display("FAIL random_c%0d: got %b want %b", i, obs(), exp_o);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch_priority();
      test_mem_wait();
      test_timeout();
      test_imem_stall();
`ifdef PIPE_CTRL_PERF_EN
      test_perf();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter DMEM_TIMEOUT, default 16, meaning the maximum number of MEM_WAIT cycles before error (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock (rising edge).
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port load_use_hazard, input, 1, load-use stall request from the hazard unit.
REQ-005 SHALL have port branch_taken_ex, input, 1, meaning the EX-stage branch/jump resolved taken.
REQ-006 SHALL have port dmem_req_ex, input, 1, meaning the EX-stage load/store is issuing a data-memory access.
REQ-007 SHALL have port dmem_ready, input, 1, meaning data memory completes the access this cycle.
REQ-008 SHALL have port imem_ready, input, 1, meaning instruction fetch data is valid this cycle.
REQ-009 SHALL have outputs pc_en, if_id_en, if_id_flush, id_ex_flush, ex_hold, each 1 bit: PC update enable, IF/ID load enable, IF/ID bubble, ID/EX bubble, and EX/memory-op freeze.
REQ-010 SHALL have outputs halt, 1 bit, and dmem_err, 1 bit: the pipeline is stopped, and the data-memory timeout occurred (sticky).

Function
REQ-011 SHALL implement FSM states RUN, MEM_WAIT, ERR; outputs are Mealy (state plus current inputs), and the state register and timeout counter are the only sequential elements.
REQ-012 SHALL in RUN apply this priority: (1) dmem_req_ex & !dmem_ready; (2) branch_taken_ex; (3) load_use_hazard; (4) !imem_ready; (5) none.
REQ-013 SHALL for case 1 drive pc_en=0, if_id_en=0, ex_hold=1, both flushes 0, and go to MEM_WAIT with the counter cleared to 0.
REQ-014 SHALL for case 2 drive pc_en=1, if_id_en=1, if_id_flush=1, id_ex_flush=1, ex_hold=0, and stay in RUN.
REQ-015 SHALL for case 3 drive pc_en=0, if_id_en=0, id_ex_flush=1, if_id_flush=0, ex_hold=0.
REQ-016 SHALL for case 4 drive pc_en=0, if_id_en=1, if_id_flush=1, id_ex_flush=0, ex_hold=0.
REQ-017 SHALL for case 5 drive pc_en=1, if_id_en=1, and all flushes and ex_hold 0.
REQ-018 SHALL in MEM_WAIT with dmem_ready=0 drive the case-1 outputs and increment the counter; when the counter equals DMEM_TIMEOUT-1 it SHALL go to ERR.
REQ-019 SHALL in MEM_WAIT with dmem_ready=1 drive outputs per RUN priority cases 3..5 (branch and dmem terms ignored) and go to RUN the same edge.
REQ-020 SHALL in ERR drive pc_en=0, if_id_en=0, ex_hold=1, flushes 0, halt=1, dmem_err=1, and remain in ERR until reset.
REQ-021 SHALL drive halt=0 and dmem_err=0 in RUN and MEM_WAIT.
REQ-022 SHALL use a counter width of $clog2(DMEM_TIMEOUT); the counter never wraps, because the transition to ERR precedes overflow.
REQ-023 SHALL treat dmem_req_ex & dmem_ready in the same RUN cycle as zero-wait (no MEM_WAIT entry).

Reset
REQ-024 SHALL on rst_n low immediately force state=RUN and counter=0; outputs then follow RUN decoding (case 5 with idle inputs: pc_en=1, if_id_en=1, others 0).
REQ-025 SHALL on reset asserted mid-MEM_WAIT or in ERR abandon the wait and clear dmem_err without waiting for a clock edge.

Configuration
REQ-026 SHALL, when macro PIPE_CTRL_PERF_EN is defined, add outputs stall_cycles[31:0] (cycles with pc_en=0) and flush_count[31:0] (cycles with id_ex_flush=1), both saturating at 32'hFFFF_FFFF and reset to 0.
REQ-027 SHALL, when PIPE_CTRL_PERF_EN is undefined, omit those ports and counters entirely, with all other behaviour identical.

Structure
REQ-028 SHALL place the state enum (RUN/MEM_WAIT/ERR) and the default DMEM_TIMEOUT constant in shared package pipe_ctrl_pkg.
REQ-029 SHALL implement the perf counters as two instances of sub-module sat_counter (32-bit, enable input, saturating), instantiated only under PIPE_CTRL_PERF_EN.

Verification
REQ-030 SHALL cover: load_use_hazard=1 for 1 cycle in RUN -> that cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all normal.
REQ-031 SHALL cover: branch_taken_ex=1 together with load_use_hazard=1 -> pc_en=1, if_id_flush=1, id_ex_flush=1 (branch wins).
REQ-032 SHALL cover: dmem_req_ex=1 at cycle 1 with dmem_ready rising at cycle 3 -> ex_hold=1 in cycles 1-2, state MEM_WAIT in cycles 2-3, ex_hold=0 in cycle 3, RUN from cycle 4.
REQ-033 SHALL cover: DMEM_TIMEOUT=4 with dmem_req_ex at cycle 1 and dmem_ready held 0 -> MEM_WAIT in cycles 2-5, halt=1 and dmem_err=1 from cycle 6, sticky; rst_n pulse clears them asynchronously.
REQ-034 SHALL cover: imem_ready=0 for 2 cycles -> pc_en=0, if_id_flush=1, id_ex_flush=0 in both cycles.
REQ-035 SHALL cover: with PIPE_CTRL_PERF_EN, the REQ-030 and REQ-031 sequence -> stall_cycles=1 and flush_count=2.
